subslot_expander: RTL and testbench
===================================

// Module: subslot_expander
// PURPOSE
//  Parametrised secondary-slot expander register bank for the MSX slot decoder. Holds one
//  8-bit subslot register per primary slot, accessed at REG_ADDR when that slot is expanded.
//  Exactly one register action per bus cycle, registered readback, a change strobe, and a
//  settle window that stretches the CPU while downstream decoders retarget after a change.
// PARAMETERS
//  SLOTS          4        number of primary slots (power of 2, 2..8)
//  REG_ADDR       16'hFFFF address of the subslot register
//  INVERT_READ    1        1: readback = ~register (MSX standard); 0: readback = register
//  RESET_VALUE    8'h00    value of every subslot register after reset
//  SETTLE_CYCLES  2        wait cycles after a value-changing write; 0 disables (max 255)
// PORTS
//  cpu_bus.clk      in   1   system clock (interface cpu_bus_if.device_mp)
//  cpu_bus.reset    in   1   synchronous, active-high reset
//  cpu_bus.addr/data/mreq/rd/wr  in  16/8/1/1/1  CPU bus fields
//  active_slot      in   $clog2(SLOTS)  currently selected primary slot
//  expander_enable  in   SLOTS   bit n = primary slot n is expanded
//  data             out  8   readback byte; 8'hFF when not driving
//  output_rq        out  1   high while data carries register readback
//  active_subslot   out  2   subslot for current page of active_slot
//  wait_n           out  1   low = stretch CPU cycle (settle window)
//  subslot_changed  out  1   1-cycle pulse when a register value changed
//  changed_slot     out  $clog2(SLOTS)  slot index qualified by subslot_changed
// BEHAVIOUR
//  - hit = mreq & addr==REG_ADDR & expander_enable[active_slot] & (rd|wr); wr wins if rd&wr.
//  - Access FSM: IDLE -> (hit) SERVICED -> (mreq==0) IDLE. Action happens only on the
//    IDLE->SERVICED edge; a bus cycle held many clocks gives exactly one action.
//  - Write: reg[active_slot] <= cpu_bus.data at the servicing edge; visible next cycle.
//  - Read: data/output_rq registered: valid from cycle after servicing edge while in
//    SERVICED with rd=1; data = INVERT_READ ? ~reg : reg. Otherwise data=8'hFF, rq=0.
//  - Changed write (new != old): subslot_changed=1 and changed_slot=slot in the cycle
//    after the edge; settle counter loads SETTLE_CYCLES, wait_n=0 while counter!=0,
//    decrements 1/clk. Equal-value write: no strobe, no settle.
//  - Write during active settle reloads the counter (if value changes).
//  - active_subslot = reg[active_slot][2*addr[15:14] +: 2], combinational; 2'b00 when
//    expander_enable[active_slot]==0. Non-expanded slot: writes ignored, reads not hit.
//  - Reset (sync): all regs=RESET_VALUE, data=8'hFF, output_rq=0, wait_n=1,
//    subslot_changed=0, changed_slot=0, counter=0, FSM=SERVICED (an access straddling
//    reset is ignored until mreq drops). Reset mid-settle aborts the window.
//  - active_slot change while in SERVICED: no new action; read data not re-sampled.
// STRUCTURE
//  - slot_pkg: slot_idx_t, subslot_t (logic[1:0]), access_state_e {IDLE,SERVICED}.
//  - Sub-module subslot_settle_timer (load/value/busy down-counter, width 8).
//  - Register array, FSM and readback register in top level.
// TESTING
//  - Reset, slot0 expanded, write 8'h1B @FFFF slot0 -> next cycle page0..3 subslots
//    3,2,1,0; read @FFFF -> data 8'hE4, output_rq=1 one cycle after edge.
//  - Write held mreq 10 clocks with data changing mid-cycle -> only first value stored,
//    one subslot_changed pulse, wait_n low exactly 2 cycles (SETTLE_CYCLES=2).
//  - Repeat same value write -> no pulse, wait_n stays 1; write during settle with new
//    value -> counter reloaded, wait_n low 2 cycles from second edge.
//  - expander_enable=4'b0010, write @FFFF on slot0 -> ignored, active_subslot=0, data=FF;
//    on slot1 -> stored; INVERT_READ=0 build read -> raw value.
//  - Reset asserted during settle with mreq still high -> wait_n=1, regs=RESET_VALUE,
//    no write after reset release until mreq deasserts and reasserts.
//  - SLOTS=8 build: independent values in slots 0..7, readback each matches.

Source files
------------

// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types and helpers for the subslot expander
package slot_pkg;

  localparam int MAX_SLOTS = 8;

  typedef logic [2:0] slot_idx_t;
  typedef logic [1:0] subslot_t;
  typedef enum logic [0:0] {IDLE = 1'b0, SERVICED = 1'b1} access_state_e;

  // Pick the 2-bit subslot field for a 16 KiB page out of a subslot register
  function automatic subslot_t page_subslot(input logic [7:0] value, input logic [1:0] page);
    return value[2*page +: 2];
  endfunction

endpackage

// File: rtl/cpu_bus_if.sv
// rtl/cpu_bus_if.sv - CPU memory bus seen by slot-decoder devices
interface cpu_bus_if (input logic clk);
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        mreq;
  logic        rd;
  logic        wr;

  modport device_mp (input clk, reset, addr, data, mreq, rd, wr);
endinterface

// File: rtl/subslot_settle_timer.sv
// rtl/subslot_settle_timer.sv - loadable down-counter that flags the settle window
module subslot_settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             busy
);

  logic [WIDTH-1:0] count;

  // Load on a value-changing write (reload wins over decrement), then count down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/subslot_expander.sv
// rtl/subslot_expander.sv - per-slot secondary slot registers with readback and settle stretch
module subslot_expander
  import slot_pkg::*;
#(
  parameter int          SLOTS         = 4,
  parameter logic [15:0] REG_ADDR      = 16'hFFFF,
  parameter bit          INVERT_READ   = 1'b1,
  parameter logic [7:0]  RESET_VALUE   = 8'h00,
  parameter int          SETTLE_CYCLES = 2,
  localparam int         SW            = $clog2(SLOTS)
) (
  cpu_bus_if.device_mp      cpu_bus,
  input  logic [SW-1:0]     active_slot,
  input  logic [SLOTS-1:0]  expander_enable,
  output logic [7:0]        data,
  output logic              output_rq,
  output subslot_t          active_subslot,
  output logic              wait_n,
  output logic              subslot_changed,
  output logic [SW-1:0]     changed_slot
);

  localparam logic [0:0] ST_IDLE     = IDLE;
  localparam logic [0:0] ST_SERVICED = SERVICED;

  logic [7:0] regs [SLOTS];
  logic [0:0] state;
  logic [7:0] cur_value;
  logic [7:0] read_value;
  logic       hit;
  logic       service;
  logic       do_write;
  logic       do_read;
  logic       settle_load;
  logic       settle_busy;

  assign cur_value   = regs[active_slot];
  assign hit         = cpu_bus.mreq && (cpu_bus.addr == REG_ADDR) &&
                       expander_enable[active_slot] && (cpu_bus.rd || cpu_bus.wr);
  // Only the first clock of a bus cycle acts; the FSM blocks repeats until mreq drops
  assign service     = (state == ST_IDLE) && hit;
  assign do_write    = service && cpu_bus.wr;
  assign do_read     = service && cpu_bus.rd && !cpu_bus.wr;
  assign settle_load = do_write && (cpu_bus.data != cur_value);
  assign read_value  = INVERT_READ ? ~cur_value : cur_value;

  // Access FSM; reset parks in SERVICED so an access straddling reset is ignored
  always_ff @(posedge cpu_bus.clk) begin
    if (cpu_bus.reset) begin
      state <= ST_SERVICED;
    end else if (state == ST_IDLE) begin
      if (hit) state <= ST_SERVICED;
    end else if (!cpu_bus.mreq) begin
      state <= ST_IDLE;
    end
  end

  // Subslot register bank, written once per serviced write cycle
  always_ff @(posedge cpu_bus.clk) begin
    if (cpu_bus.reset) begin
      for (int i = 0; i < SLOTS; i++) regs[i] <= RESET_VALUE;
    end else if (do_write) begin
      regs[active_slot] <= cpu_bus.data;
    end
  end

  // Change strobe and the slot it refers to
  always_ff @(posedge cpu_bus.clk) begin
    if (cpu_bus.reset) begin
      subslot_changed <= 1'b0;
      changed_slot    <= '0;
    end else begin
      subslot_changed <= settle_load;
      if (settle_load) changed_slot <= active_slot;
    end
  end

  // Readback captured at the servicing edge and held while the read cycle continues
  always_ff @(posedge cpu_bus.clk) begin
    if (cpu_bus.reset) begin
      data      <= 8'hFF;
      output_rq <= 1'b0;
    end else if (do_read) begin
      data      <= read_value;
      output_rq <= 1'b1;
    end else if (!(output_rq && (state == ST_SERVICED) && cpu_bus.mreq && cpu_bus.rd)) begin
      data      <= 8'hFF;
      output_rq <= 1'b0;
    end
  end

  // Page subslot for the decoder; unexpanded slots always report subslot 0
  always_comb begin
    active_subslot = '0;
    if (expander_enable[active_slot]) begin
      active_subslot = page_subslot(cur_value, cpu_bus.addr[15:14]);
    end
  end

  subslot_settle_timer #(.WIDTH(8)) u_settle (
    .clk   (cpu_bus.clk),
    .reset (cpu_bus.reset),
    .load  (settle_load),
    .value (8'(SETTLE_CYCLES)),
    .busy  (settle_busy)
  );

  assign wait_n = !settle_busy;

endmodule

// File: tb/tb_subslot_expander.sv
// tb/tb_subslot_expander.sv - directed self-checking bench for subslot_expander
module tb_subslot_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_if bus (.clk(clk));

  logic [1:0] a_slot, r_slot;
  logic [2:0] e_slot;
  logic [3:0] a_en, r_en;
  logic [7:0] e_en;
  logic [7:0] a_data, r_data, e_data;
  logic       a_rq, r_rq, e_rq;
  logic [1:0] a_sub, r_sub, e_sub;
  logic       a_wait, r_wait, e_wait;
  logic       a_chg, r_chg, e_chg;
  logic [1:0] a_cslot, r_cslot;
  logic [2:0] e_cslot;

  int checks = 0;
  int errors = 0;
  int pulses, waitlow;
  logic [7:0] val;

  subslot_expander u_a (
    .cpu_bus(bus), .active_slot(a_slot), .expander_enable(a_en), .data(a_data),
    .output_rq(a_rq), .active_subslot(a_sub), .wait_n(a_wait),
    .subslot_changed(a_chg), .changed_slot(a_cslot));

  subslot_expander #(.INVERT_READ(1'b0)) u_r (
    .cpu_bus(bus), .active_slot(r_slot), .expander_enable(r_en), .data(r_data),
    .output_rq(r_rq), .active_subslot(r_sub), .wait_n(r_wait),
    .subslot_changed(r_chg), .changed_slot(r_cslot));

  subslot_expander #(.SLOTS(8)) u_e (
    .cpu_bus(bus), .active_slot(e_slot), .expander_enable(e_en), .data(e_data),
    .output_rq(e_rq), .active_subslot(e_sub), .wait_n(e_wait),
    .subslot_changed(e_chg), .changed_slot(e_cslot));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] d);
    bus.addr = 16'hFFFF; bus.data = d; bus.mreq = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
    tick();
  endtask

  task automatic bus_read();
    bus.addr = 16'hFFFF; bus.mreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0;
    tick();
  endtask

  task automatic bus_release();
    bus.mreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000;
    tick();
  endtask

  initial begin
    bus.reset = 1'b1; bus.addr = 16'h0000; bus.data = 8'h00;
    bus.mreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    a_slot = 2'd0; a_en = 4'b0001; r_slot = 2'd0; r_en = 4'b0000;
    e_slot = 3'd0; e_en = 8'h00;
    tick(); tick();
    chk("reset_data", a_data, 8'hFF);
    chk("reset_rq", a_rq, 1'b0);
    chk("reset_wait_n", a_wait, 1'b1);
    chk("reset_changed", a_chg, 1'b0);
    chk("reset_changed_slot", a_cslot, 2'd0);
    chk("reset_subslot", a_sub, 2'd0);
    bus.reset = 1'b0;
    tick();

    // Basic write and page decode
    bus_write(8'h1B);
    chk("wr_pulse", a_chg, 1'b1);
    chk("wr_changed_slot", a_cslot, 2'd0);
    chk("wr_wait_low", a_wait, 1'b0);
    bus.mreq = 1'b0; bus.wr = 1'b0;
    bus.addr = 16'h0000; #1 chk("page0", a_sub, 2'd3);
    bus.addr = 16'h4000; #1 chk("page1", a_sub, 2'd2);
    bus.addr = 16'h8000; #1 chk("page2", a_sub, 2'd1);
    bus.addr = 16'hC000; #1 chk("page3", a_sub, 2'd0);
    tick(); tick();
    chk("settle_done", a_wait, 1'b1);
    chk("rq_before_read", a_rq, 1'b0);
    bus_read();
    chk("read_rq", a_rq, 1'b1);
    chk("read_data", a_data, 8'hE4);
    tick();
    chk("read_hold", a_data, 8'hE4);
    bus_release();
    chk("read_end_rq", a_rq, 1'b0);
    chk("read_end_data", a_data, 8'hFF);

    // Write held for 10 clocks with data changing mid-cycle
    bus_write(8'h55);
    pulses = int'(a_chg); waitlow = int'(!a_wait);
    bus.data = 8'hAA;
    for (int k = 1; k < 10; k++) begin
      tick();
      pulses += int'(a_chg); waitlow += int'(!a_wait);
    end
    chk("held_pulses", pulses, 1);
    chk("held_wait_cycles", waitlow, 2);
    bus_release();
    chk("held_first_value", a_sub, 2'd1);

    // Same-value write does nothing visible
    bus_write(8'h55);
    chk("same_no_pulse", a_chg, 1'b0);
    chk("same_no_wait", a_wait, 1'b1);
    bus_release();

    // Write during settle reloads the counter
    bus_write(8'h11);
    bus_release();
    chk("settle_mid", a_wait, 1'b0);
    bus_write(8'h22);
    chk("reload_pulse", a_chg, 1'b1);
    chk("reload_wait0", a_wait, 1'b0);
    bus_release();
    chk("reload_wait1", a_wait, 1'b0);
    tick();
    chk("reload_wait2", a_wait, 1'b1);

    // Non-expanded slot 0 ignores writes and reads
    a_en = 4'b0010; a_slot = 2'd0;
    bus_write(8'h77);
    chk("noexp_no_pulse", a_chg, 1'b0);
    chk("noexp_no_wait", a_wait, 1'b1);
    bus_release();
    chk("noexp_subslot", a_sub, 2'd0);
    bus_read();
    chk("noexp_rq", a_rq, 1'b0);
    chk("noexp_data", a_data, 8'hFF);
    bus_release();
    a_slot = 2'd1;
    bus_write(8'h9C);
    chk("slot1_pulse", a_chg, 1'b1);
    chk("slot1_changed_slot", a_cslot, 2'd1);
    bus_release(); tick();
    bus.addr = 16'hC000; #1 chk("slot1_page3", a_sub, 2'd2);
    bus_read();
    chk("slot1_read", a_data, 8'h63);
    bus_release();
    a_en = 4'b0001; a_slot = 2'd0; #1
    chk("slot0_kept", a_sub, 2'd2);

    // Non-inverting build returns the raw register
    a_en = 4'b0000; r_en = 4'b0001;
    bus_write(8'h5A);
    bus_release(); tick();
    bus_read();
    chk("raw_rq", r_rq, 1'b1);
    chk("raw_data", r_data, 8'h5A);
    bus_release();
    r_en = 4'b0000;

    // Reset in the middle of a settle window with mreq held
    a_en = 4'b0001; a_slot = 2'd0;
    bus_write(8'hE5);
    chk("pre_reset_wait", a_wait, 1'b0);
    bus.reset = 1'b1;
    tick();
    chk("mid_reset_wait", a_wait, 1'b1);
    chk("mid_reset_data", a_data, 8'hFF);
    bus.reset = 1'b0;
    tick(); tick();
    chk("post_reset_no_pulse", a_chg, 1'b0);
    chk("post_reset_no_write", a_sub, 2'd0);
    bus_release();
    bus_write(8'hE5);
    chk("rearm_pulse", a_chg, 1'b1);
    bus_release();
    bus.addr = 16'hC000; #1 chk("rearm_stored", a_sub, 2'd3);
    a_en = 4'b0000;

    // Eight-slot build keeps independent registers
    e_en = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      e_slot = 3'(i);
      bus_write(8'(i * 37 + 5));
      bus_release();
    end
    chk("e8_changed_slot", e_cslot, 3'd7);
    for (int i = 0; i < 8; i++) begin
      e_slot = 3'(i);
      val = ~8'(i * 37 + 5);
      bus_read();
      chk($sformatf("e8_read_slot%0d", i), e_data, val);
      bus_release();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
